// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl_if
// Brief    : Bundles the fetch controller's control inputs, instruction-memory
//            port and IF/ID outputs into one interface.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc4;
    logic              if_valid;
    logic              halted;
    logic [15:0]       fetch_count;

    // Fetch controller side
    modport master (
        input  stall, redirect, redirect_pc, imem_data,
        output imem_addr, if_instr, if_pc4, if_valid, halted, fetch_count
    );

    // Pipeline / memory environment side
    modport slave (
        output stall, redirect, redirect_pc, imem_data,
        input  imem_addr, if_instr, if_pc4, if_valid, halted, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Instruction fetch controller with PC, IF/ID register, stall,
//            redirect and end-of-program halt; counts delivered instructions.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int NUM_INSTR = 30
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    // The PC is kept as a word index so the byte address is always aligned.
    localparam logic [ADDR_W-2:0] c_END_WORD = (ADDR_W-1)'(NUM_INSTR);
    localparam logic [ADDR_W-2:0] c_ONE      = (ADDR_W-1)'(1);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t            r_state,       w_state_nxt;
    logic [ADDR_W-3:0] r_pc_word,     w_pc_word_nxt;
    logic [31:0]       r_if_instr,    w_if_instr_nxt;
    logic [ADDR_W-1:0] r_if_pc4,      w_if_pc4_nxt;
    logic              r_if_valid,    w_if_valid_nxt;
    logic [15:0]       r_fetch_count, w_fetch_count_nxt;

    // One extra bit so the end compare sees PC+4 before any modulo wrap.
    logic [ADDR_W-2:0] w_pc_inc;
    logic [ADDR_W-3:0] w_tgt_word;
    logic              w_pc_inc_end;
    logic              w_tgt_end;
    logic              w_unused_rpc;

    assign w_pc_inc     = {1'b0, r_pc_word} + c_ONE;
    assign w_pc_inc_end = (w_pc_inc >= c_END_WORD);
    assign w_tgt_word   = bus.redirect_pc[ADDR_W-1:2];
    assign w_tgt_end    = ({1'b0, w_tgt_word} >= c_END_WORD);
    // Redirect targets are forced to word alignment; the byte offset is dropped.
    assign w_unused_rpc = ^bus.redirect_pc[1:0];

    // Next-state and IF/ID update: redirect first, then RUN fetch/stall, HALT idle.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_word_nxt     = r_pc_word;
        w_if_instr_nxt    = r_if_instr;
        w_if_pc4_nxt      = r_if_pc4;
        w_if_valid_nxt    = r_if_valid;
        w_fetch_count_nxt = r_fetch_count;

        if (bus.redirect) begin
            w_pc_word_nxt  = w_tgt_word;
            w_if_valid_nxt = 1'b0;
            w_state_nxt    = w_tgt_end ? HALT : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (!bus.stall) begin
                        w_if_instr_nxt = bus.imem_data;
                        w_if_pc4_nxt   = {w_pc_inc[ADDR_W-3:0], 2'b00};
                        w_if_valid_nxt = 1'b1;
                        w_pc_word_nxt  = w_pc_inc[ADDR_W-3:0];
                        if (r_fetch_count != 16'hFFFF) begin
                            w_fetch_count_nxt = r_fetch_count + 16'd1;
                        end
                        if (w_pc_inc_end) begin
                            w_state_nxt = HALT;
                        end
                    end
                end
                HALT: begin
                    w_if_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_pc_word     <= '0;
            r_if_instr    <= '0;
            r_if_pc4      <= '0;
            r_if_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_word     <= w_pc_word_nxt;
            r_if_instr    <= w_if_instr_nxt;
            r_if_pc4      <= w_if_pc4_nxt;
            r_if_valid    <= w_if_valid_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign bus.imem_addr   = {r_pc_word, 2'b00};
    assign bus.if_instr    = r_if_instr;
    assign bus.if_pc4      = r_if_pc4;
    assign bus.if_valid    = r_if_valid;
    assign bus.halted      = (r_state == HALT);
    assign bus.fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Self-checking bench for fetch_ctrl: directed vector table plus
//            hand-written run-to-end and halt sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    fetch_ctrl_if #(.ADDR_W(7)) bus ();

    fetch_ctrl #(.ADDR_W(7), .NUM_INSTR(30)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory contents are a simple function of the address.
    function automatic logic [31:0] mem_word(input logic [6:0] a);
        return 32'hC0DE_0000 | {25'd0, a};
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rd;
        logic [6:0]  rpc;
        logic [6:0]  e_addr;
        logic [31:0] e_instr;
        logic [6:0]  e_pc4;
        logic        e_valid;
        logic        e_halt;
        logic [15:0] e_cnt;
        logic        chk_data;
    } vec_t;

    localparam int c_NVEC = 26;
    vec_t vt [c_NVEC];

    function automatic vec_t mk(input logic r, input logic s, input logic d,
                                input logic [6:0] rpc, input logic [6:0] ea,
                                input logic [31:0] ei, input logic [6:0] ep,
                                input logic ev, input logic eh,
                                input logic [15:0] ec, input logic cd);
        vec_t v;
        v.rst = r; v.stl = s; v.rd = d; v.rpc = rpc;
        v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep;
        v.e_valid = ev; v.e_halt = eh; v.e_cnt = ec; v.chk_data = cd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic r, input logic s, input logic d, input logic [6:0] rpc);
        reset           = r;
        bus.stall       = s;
        bus.redirect    = d;
        bus.redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;

        //           rst s  rd rpc    addr   instr             pc4    v  h  cnt cd
        vt[0]  = mk(1, 0, 0, 7'h00, 7'h00, 32'h0,            7'h00, 0, 0, 0,  1);
        vt[1]  = mk(0, 0, 0, 7'h00, 7'h04, mem_word(7'h00),  7'h04, 1, 0, 1,  1);
        vt[2]  = mk(0, 0, 0, 7'h00, 7'h08, mem_word(7'h04),  7'h08, 1, 0, 2,  1);
        vt[3]  = mk(0, 0, 0, 7'h00, 7'h0C, mem_word(7'h08),  7'h0C, 1, 0, 3,  1);
        vt[4]  = mk(0, 0, 0, 7'h00, 7'h10, mem_word(7'h0C),  7'h10, 1, 0, 4,  1);
        vt[5]  = mk(0, 0, 0, 7'h00, 7'h14, mem_word(7'h10),  7'h14, 1, 0, 5,  1);
        vt[6]  = mk(0, 0, 0, 7'h00, 7'h18, mem_word(7'h14),  7'h18, 1, 0, 6,  1);
        vt[7]  = mk(0, 0, 0, 7'h00, 7'h1C, mem_word(7'h18),  7'h1C, 1, 0, 7,  1);
        vt[8]  = mk(0, 0, 0, 7'h00, 7'h20, mem_word(7'h1C),  7'h20, 1, 0, 8,  1);
        vt[9]  = mk(0, 1, 0, 7'h00, 7'h20, mem_word(7'h1C),  7'h20, 1, 0, 8,  1);
        vt[10] = mk(0, 1, 0, 7'h00, 7'h20, mem_word(7'h1C),  7'h20, 1, 0, 8,  1);
        vt[11] = mk(0, 0, 0, 7'h00, 7'h24, mem_word(7'h20),  7'h24, 1, 0, 9,  1);
        vt[12] = mk(0, 1, 1, 7'h3B, 7'h38, 32'h0,            7'h00, 0, 0, 9,  0);
        vt[13] = mk(0, 0, 0, 7'h00, 7'h3C, mem_word(7'h38),  7'h3C, 1, 0, 10, 1);
        vt[14] = mk(0, 0, 1, 7'h7C, 7'h7C, 32'h0,            7'h00, 0, 1, 10, 0);
        vt[15] = mk(0, 1, 0, 7'h00, 7'h7C, 32'h0,            7'h00, 0, 1, 10, 0);
        vt[16] = mk(1, 1, 0, 7'h00, 7'h00, 32'h0,            7'h00, 0, 0, 0,  1);
        vt[17] = mk(0, 0, 0, 7'h00, 7'h04, mem_word(7'h00),  7'h04, 1, 0, 1,  1);
        vt[18] = mk(0, 0, 1, 7'h6C, 7'h6C, 32'h0,            7'h00, 0, 0, 1,  0);
        vt[19] = mk(0, 0, 0, 7'h00, 7'h70, mem_word(7'h6C),  7'h70, 1, 0, 2,  1);
        vt[20] = mk(0, 0, 0, 7'h00, 7'h74, mem_word(7'h70),  7'h74, 1, 0, 3,  1);
        vt[21] = mk(0, 0, 0, 7'h00, 7'h78, mem_word(7'h74),  7'h78, 1, 1, 4,  1);
        vt[22] = mk(0, 0, 0, 7'h00, 7'h78, 32'h0,            7'h00, 0, 1, 4,  0);
        vt[23] = mk(0, 0, 1, 7'h0C, 7'h0C, 32'h0,            7'h00, 0, 0, 4,  0);
        vt[24] = mk(0, 0, 0, 7'h00, 7'h10, mem_word(7'h0C),  7'h10, 1, 0, 5,  1);
        vt[25] = mk(1, 0, 1, 7'h40, 7'h00, 32'h0,            7'h00, 0, 0, 0,  1);

        for (int i = 0; i < c_NVEC; i++) begin
            step(vt[i].rst, vt[i].stl, vt[i].rd, vt[i].rpc);
            check($sformatf("v%0d.addr", i),  32'(bus.imem_addr),   32'(vt[i].e_addr));
            check($sformatf("v%0d.valid", i), 32'(bus.if_valid),    32'(vt[i].e_valid));
            check($sformatf("v%0d.halt", i),  32'(bus.halted),      32'(vt[i].e_halt));
            check($sformatf("v%0d.cnt", i),   32'(bus.fetch_count), 32'(vt[i].e_cnt));
            if (vt[i].chk_data) begin
                check($sformatf("v%0d.instr", i), bus.if_instr,     vt[i].e_instr);
                check($sformatf("v%0d.pc4", i),   32'(bus.if_pc4),  32'(vt[i].e_pc4));
            end
        end

        // Free run from address 0 through the last word; HALT on the 30th fetch.
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 0, 7'h00);
            check($sformatf("run%0d.addr", k),  32'(bus.imem_addr), k * 4);
            check($sformatf("run%0d.instr", k), bus.if_instr,       mem_word(7'((k - 1) * 4)));
            check($sformatf("run%0d.pc4", k),   32'(bus.if_pc4),    k * 4);
            check($sformatf("run%0d.valid", k), 32'(bus.if_valid),  1);
            check($sformatf("run%0d.halt", k),  32'(bus.halted),    (k == 30) ? 1 : 0);
        end
        check("run.cnt", 32'(bus.fetch_count), 30);

        // Idle in HALT: bubble, PC held, stall ignored.
        step(0, 1, 0, 7'h00);
        check("halt.addr",  32'(bus.imem_addr),   32'h78);
        check("halt.valid", 32'(bus.if_valid),    0);
        check("halt.halt",  32'(bus.halted),      1);
        check("halt.cnt",   32'(bus.fetch_count), 30);

        // Out-of-range redirect while halted loads PC but stays halted.
        step(0, 0, 1, 7'h7C);
        check("oor.addr", 32'(bus.imem_addr), 32'h7C);
        check("oor.halt", 32'(bus.halted),    1);

        // In-range redirect (with stall) resumes RUN at word 0.
        step(0, 1, 1, 7'h02);
        check("resume.addr",  32'(bus.imem_addr), 32'h00);
        check("resume.halt",  32'(bus.halted),    0);
        check("resume.valid", 32'(bus.if_valid),  0);
        step(0, 0, 0, 7'h00);
        check("resume1.instr", bus.if_instr,          mem_word(7'h00));
        check("resume1.addr",  32'(bus.imem_addr),    32'h04);
        check("resume1.cnt",   32'(bus.fetch_count),  31);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_W, default 7, meaning the byte-address width of the instruction memory port.
REQ-002 SHALL provide parameter NUM_INSTR, default 30, meaning the count of valid instruction words; the end address is NUM_INSTR*4.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port stall, input, 1 bit: hazard stall from decode; holds PC and the IF/ID register.
REQ-006 SHALL provide port redirect, input, 1 bit: taken branch or jump resolved downstream.
REQ-007 SHALL provide port redirect_pc, input, ADDR_W bits: byte target of the redirect.
REQ-008 SHALL provide port imem_addr, output, ADDR_W bits: byte address driven to the combinational instruction memory.
REQ-009 SHALL provide port imem_data, input, 32 bits: instruction word returned for imem_addr in the same cycle.
REQ-010 SHALL provide port if_instr, output, 32 bits: IF/ID registered instruction.
REQ-011 SHALL provide port if_pc4, output, ADDR_W bits: IF/ID registered PC+4 of if_instr.
REQ-012 SHALL provide port if_valid, output, 1 bit: IF/ID holds a real instruction (0 means bubble).
REQ-013 SHALL provide port halted, output, 1 bit: controller is in the HALT state.
REQ-014 SHALL provide port fetch_count, output, 16 bits: saturating count of instructions delivered with if_valid=1.

Function
REQ-015 SHALL keep a PC register and drive imem_addr = PC combinationally, with bits [1:0] always 0.
REQ-016 SHALL implement the states RUN and HALT.
REQ-017 In RUN with stall=0 and redirect=0, SHALL on each edge latch if_instr<=imem_data, if_pc4<=PC+4 and if_valid<=1, and set PC<=PC+4; this gives one-cycle fetch latency.
REQ-018 In RUN with stall=1 and redirect=0, SHALL hold PC, if_instr, if_pc4 and if_valid unchanged.
REQ-019 On redirect=1 in any state, SHALL take priority over stall and halt: PC<={redirect_pc[ADDR_W-1:2],2'b00} and if_valid<=0 (flush); if_instr and if_pc4 are don't-care.
REQ-020 A redirect whose target is >= NUM_INSTR*4 SHALL load PC and enter HALT on the next edge.
REQ-021 SHALL move RUN->HALT on the edge where the next PC would equal or exceed NUM_INSTR*4; the word at NUM_INSTR*4-4 is still delivered with if_valid=1.
REQ-022 In HALT, SHALL set if_valid<=0, hold PC, assert halted=1 and ignore stall; only redirect to an in-range target returns the block to RUN.
REQ-023 PC arithmetic SHALL be ADDR_W bits modulo 2^ADDR_W; wrap is unreachable in RUN because of REQ-021.
REQ-024 fetch_count SHALL increment on each edge where if_valid is loaded with 1, and SHALL saturate at 0xFFFF.
REQ-025 Stall SHALL NOT increment fetch_count; a held valid instruction is counted once.

Reset
REQ-026 While reset=1 at an edge, SHALL set PC=0, state=RUN, if_valid=0, if_instr=0, if_pc4=0, fetch_count=0, halted=0; this applies mid-operation and overrides stall and redirect.
REQ-027 On the first edge after reset deasserts, SHALL fetch word 0.

Verification
REQ-028 Reset, then 3 free-running cycles -> imem_addr 0,4,8,0xC; if_pc4 = 4,8,0xC; if_valid=1 from cycle 1; fetch_count=3.
REQ-029 stall=1 for 2 cycles at PC=0x20 -> imem_addr stays 0x20, IF/ID frozen, fetch_count unchanged; fetching resumes at 0x20 after release.
REQ-030 redirect=1 with redirect_pc=0x3B and stall=1 at the same time -> next PC=0x38 and if_valid=0; the next cycle delivers word 14 with if_pc4=0x3C.
REQ-031 Run to the end (NUM_INSTR=30) -> the word at 0x74 is delivered with if_valid=1, then halted=1, if_valid=0 and imem_addr holds 0x78; a later redirect to 0x0C resumes RUN.
REQ-032 redirect_pc=0x7C -> HALT the next cycle, if_valid=0, with no wrap.
REQ-033 reset=1 asserted in HALT with stall=1 -> all outputs return to their REQ-026 values on the next edge.
